bus_generator_arbiter: RTL and testbench
========================================

Name: bus_generator_arbiter

Overview:
- Shared-bus generator and arbiter connecting `drvrs` agents over `bits` independent buses.
- Each agent exposes a first-word-fall-through (FWFT) TX FIFO via `pndng`/`pop`/`D_pop` and an RX FIFO via `push`/`D_push`.
- Per bus, the block grants one pending agent round-robin, pops one packet, and routes it by the 8-bit ID in the packet MSBs: unicast to one agent, or broadcast to all other agents.
- Sits between the agent FIFOs (driver/monitor side) and is the only bus master.

Parameters:
- `bits`, 1: number of independent buses, each with its own arbiter; ≥1.
- `drvrs`, 4: agents per bus; 2..255.
- `pckg_sz`, 16: packet width; ≥9; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- `broadcast`, 8'hFF: ID value meaning "deliver to all agents except the source"; must be ≥ `drvrs`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pndng` in bits*drvrs: index b*drvrs+d; agent d on bus b has a packet at its TX FIFO head.
- `pop` out bits*drvrs: one-cycle pulse; dequeue the head of agent d's TX FIFO on bus b.
- `D_pop` in bits*drvrs*pckg_sz: TX FIFO head data per agent (FWFT, valid while `pndng`=1).
- `push` out bits*drvrs: one-cycle pulse; write `D_push` into agent d's RX FIFO.
- `D_push` out bits*drvrs*pckg_sz: delivered packet, same value driven on every agent slice of a bus.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- Buses are fully independent; all logic below is per bus b.
- State machine: IDLE → POP → PUSH → IDLE.
- IDLE:
  - If any `pndng` bit is set, register grant g = first set index searching upward (wrapping) from `last`+1; go to POP.
  - Otherwise stay in IDLE.
- POP (1 cycle):
  - `pop[g]`=1, all other `pop` bits 0.
  - Latch `D_pop[g]` into the packet register; go to PUSH.
- PUSH (1 cycle): drive `D_push` = latched packet on all slices. Let id = packet[pckg_sz-1 -: 8].
  - id == `broadcast`: `push`=1 for every agent ≠ g.
  - id < `drvrs` and id ≠ g: `push[id]`=1.
  - id == g, or id ≥ `drvrs` and ≠ `broadcast`: packet dropped, no `push`.
  - Set `last`=g; go to IDLE.
- Throughput: at most one packet per 3 cycles per bus. `pop` is asserted 1 cycle after the grant; `push` 1 cycle after `pop`.
- Fairness: round-robin over `last`. With all agents pending, grants go 0,1,2,3,0,…
- `pndng` is sampled only in IDLE; changes during POP/PUSH are ignored.
- `pop`/`push` are never asserted in the same cycle on the same bus.
- Reset values:
  - state=IDLE, `last`=drvrs-1 (so the first grant searches from agent 0).
  - `pop`=0, `push`=0, `D_push`=0, packet register=0.
- Reset mid-operation: an in-flight packet is discarded with no `push`. Outputs are zero on the cycle after `rst` is sampled high.
- `D_push` holds its last value in IDLE and POP (not cleared).

Optional Feature:
- Macro: `BUS_DROP_CNT_EN`.
- Defined:
  - Adds output `drop_cnt` [16*bits], one 16-bit counter per bus.
  - Counter increments in the PUSH cycle of every dropped packet (self-addressed or invalid ID).
  - Saturates at 16'hFFFF; cleared by `rst`.
- Undefined: port and logic absent; drops are silent. Data-path behaviour is otherwise identical.

Test Plan:
- All-to-one:
  - Stimulus: agents 0,1,3 each hold one packet with ID 2 (e.g. 16'h02A1, 16'h02B2, 16'h02C3); drivers=4, bits=1.
  - Required: `pop` order 0,1,3. `push[2]` pulses 3 times carrying 02A1, 02B2, 02C3, each exactly 1 cycle after the matching `pop`. No other `push` bit asserts.
- Normal unicast:
  - Stimulus: agent 0 sends 16'h0155.
  - Required: `pop[0]` 1 cycle after grant, then `push[1]`=1 with `D_push`=16'h0155 on the next cycle.
- Broadcast:
  - Stimulus: agent 2 sends 16'hFF7E.
  - Required: `push`=4'b1011 for one cycle with `D_push`=16'hFF7E.
- Drop:
  - Stimulus: agent 1 sends 16'h0101 (self), then 16'h0904 (ID 9, invalid).
  - Required: two `pop` pulses, no `push`. With `BUS_DROP_CNT_EN` defined, `drop_cnt`=2.
- Round-robin:
  - Stimulus: all 4 agents continuously pending.
  - Required: grant sequence 0,1,2,3,0, with one `pop` every 3 cycles.
- Reset mid-packet:
  - Stimulus: assert `rst` during the POP cycle.
  - Required: no `push` follows. After release, the first grant goes to the lowest pending agent (0 if pending).

Source files
------------

// File: rtl/bus_generator_arbiter.sv
// Multi-bus round-robin arbiter: pops one packet from a pending agent and routes it by ID.
// Optional macro BUS_DROP_CNT_EN adds a saturating per-bus drop counter output.
module bus_generator_arbiter #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [bits*drvrs-1:0]           pndng,
    output logic [bits*drvrs-1:0]           pop,
    input  logic [bits*drvrs*pckg_sz-1:0]   D_pop,
    output logic [bits*drvrs-1:0]           push,
    output logic [bits*drvrs*pckg_sz-1:0]   D_push
`ifdef BUS_DROP_CNT_EN
    ,
    output logic [16*bits-1:0]              drop_cnt
`endif
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t             state;
        state_t             state_nxt;
        logic [IW-1:0]      grant;
        logic [IW-1:0]      last;
        logic [IW-1:0]      rr_idx;
        logic               rr_hit;
        logic [pckg_sz-1:0] pkt;
        logic [drvrs-1:0]   pnd;
        logic [drvrs-1:0]   pop_b;
        logic [drvrs-1:0]   push_b;
        logic [7:0]         id;
        logic               drop;

        assign pnd = pndng[b*drvrs +: drvrs];
        assign id  = pkt[pckg_sz-1 -: 8];

        // Round-robin search: first pending agent strictly after the last grant.
        always_comb begin
            rr_idx = last;
            rr_hit = 1'b0;
            for (int i = 1; i <= drvrs; i++) begin
                if (!rr_hit && pnd[(int'(last) + i) % drvrs]) begin
                    rr_hit = 1'b1;
                    rr_idx = IW'((int'(last) + i) % drvrs);
                end
            end
        end

        // Next state, pop strobe and routing decode for the latched packet.
        always_comb begin
            state_nxt = state;
            pop_b     = '0;
            push_b    = '0;
            drop      = 1'b0;
            unique case (state)
                IDLE: begin
                    if (rr_hit) state_nxt = POP;
                end
                POP: begin
                    pop_b[grant] = 1'b1;
                    state_nxt    = PUSH;
                end
                PUSH: begin
                    state_nxt = IDLE;
                    if (id == broadcast) begin
                        push_b        = '1;
                        push_b[grant] = 1'b0;
                    end else if (id < 8'(drvrs) && id != 8'(grant)) begin
                        push_b[id[IW-1:0]] = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // State, grant, last-served agent and packet register.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                grant <= '0;
                last  <= IW'(drvrs - 1);
                pkt   <= '0;
            end else begin
                state <= state_nxt;
                if (state == IDLE && rr_hit) grant <= rr_idx;
                if (state == POP)
                    pkt <= D_pop[(b*drvrs + int'(grant))*pckg_sz +: pckg_sz];
                if (state == PUSH) last <= grant;
            end
        end

        assign pop[b*drvrs +: drvrs]  = pop_b;
        assign push[b*drvrs +: drvrs] = push_b;
        assign D_push[b*drvrs*pckg_sz +: drvrs*pckg_sz] = {drvrs{pkt}};

`ifdef BUS_DROP_CNT_EN
        logic [15:0] cnt;

        // Saturating count of packets discarded in the PUSH cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (drop && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign drop_cnt[16*b +: 16] = cnt;
`endif
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Bench for bus_generator_arbiter: transaction-level model plus directed scenarios.
// Agent TX FIFOs are emulated with queues driven by the DUT pop strobes.
module tb_bus_generator_arbiter;

    localparam int ND = 4;
    localparam int PW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ND-1:0]   pndng = '0;
    logic [ND-1:0]   pop;
    logic [ND*PW-1:0] D_pop = '0;
    logic [ND-1:0]   push;
    logic [ND*PW-1:0] D_push;
`ifdef BUS_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    bus_generator_arbiter #(
        .bits(1), .drvrs(ND), .pckg_sz(PW), .broadcast(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pndng(pndng),
        .pop(pop),
        .D_pop(D_pop),
        .push(push),
        .D_push(D_push)
`ifdef BUS_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] q[ND][$];
    logic [ND-1:0] pop_seen = '0;

    // transaction model state
    int            cyc = 0;
    bit            armed = 0;
    int            e_pop_cyc = -10;
    int            e_push_cyc = -10;
    logic [ND-1:0] e_pop_vec = '0;
    logic [ND-1:0] e_push_vec = '0;
    logic [PW-1:0] e_data = '0;
    logic [PW-1:0] e_dpush = '0;
    int            mlast = ND - 1;
    int            mdrop = 0;

    // observation logs for literal checks
    int            pop_log[$];
    int            pop_cyc[$];
    logic [ND-1:0] push_log[$];
    logic [PW-1:0] pdat_log[$];
    int            push_cyc[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [ND-1:0] route(input logic [7:0] id, input int g);
        logic [ND-1:0] m;
        m = '0;
        if (id == 8'hFF) begin
            m = '1;
            m[g] = 1'b0;
        end else if (id < ND && int'(id) != g) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

    function automatic void refresh();
        for (int d = 0; d < ND; d++) begin
            pndng[d] = (q[d].size() != 0);
            D_pop[d*PW +: PW] = (q[d].size() != 0) ? q[d][0] : '0;
        end
    endfunction

    // FIFO side: dequeue heads the DUT popped during the finished cycle.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < ND; d++)
            if (pop_seen[d] && q[d].size() != 0) void'(q[d].pop_front());
        refresh();
    end

    // Model advance at each clock edge: reset, drop count, new grant.
    always @(posedge clk) begin
        if (rst) begin
            armed      = 1;
            e_pop_cyc  = -10;
            e_push_cyc = -10;
            e_dpush    = '0;
            mlast      = ND - 1;
            mdrop      = 0;
        end else begin
            if (cyc == e_push_cyc && e_push_vec == '0 && mdrop < 16'hFFFF)
                mdrop++;
            if (cyc > e_push_cyc && pndng != '0) begin
                int g;
                g = -1;
                for (int k = 1; k <= ND; k++)
                    if (g < 0 && pndng[(mlast + k) % ND]) g = (mlast + k) % ND;
                e_pop_vec  = '0;
                e_pop_vec[g] = 1'b1;
                e_data     = D_pop[g*PW +: PW];
                e_push_vec = route(e_data[PW-1 -: 8], g);
                e_pop_cyc  = cyc + 1;
                e_push_cyc = cyc + 2;
                mlast      = g;
            end
        end
        cyc++;
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        pop_seen = pop;
        if (armed) begin
            if (cyc == e_push_cyc) e_dpush = e_data;
            chk("pop", pop, (cyc == e_pop_cyc) ? e_pop_vec : '0);
            chk("push", push, (cyc == e_push_cyc) ? e_push_vec : '0);
            chk("D_push", D_push[PW-1:0], e_dpush);
            for (int d = 1; d < ND; d++)
                chk("D_push_slice", D_push[d*PW +: PW], D_push[PW-1:0]);
`ifdef BUS_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, mdrop);
`endif
            if (pop != '0) begin
                for (int d = 0; d < ND; d++)
                    if (pop[d]) pop_log.push_back(d);
                pop_cyc.push_back(cyc);
            end
            if (push != '0) begin
                push_log.push_back(push);
                pdat_log.push_back(D_push[PW-1:0]);
                push_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        pop_log.delete();
        pop_cyc.delete();
        push_log.delete();
        pdat_log.delete();
        push_cyc.delete();
    endtask

    task automatic load(input int a, input logic [PW-1:0] v);
        q[a].push_back(v);
        refresh();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (pndng == '0 && cyc > e_push_cyc + 1) begin
                done = 1;
                break;
            end
        end
        chk({nm, "_drain_timeout"}, done, 1);
    endtask

    initial begin
        refresh();
        do_reset();
        @(negedge clk); #1;
        chk("reset_pop", pop, 0);
        chk("reset_push", push, 0);
        chk("reset_dpush", D_push, 0);

        // all-to-one
        clear_logs();
        @(posedge clk); #2;
        load(0, 16'h02A1);
        load(1, 16'h02B2);
        load(3, 16'h02C3);
        drain("a2o");
        chk("a2o_npop", pop_log.size(), 3);
        chk("a2o_npush", push_log.size(), 3);
        if (pop_log.size() == 3 && push_log.size() == 3) begin
            chk("a2o_pop0", pop_log[0], 0);
            chk("a2o_pop1", pop_log[1], 1);
            chk("a2o_pop2", pop_log[2], 3);
            chk("a2o_d0", pdat_log[0], 16'h02A1);
            chk("a2o_d1", pdat_log[1], 16'h02B2);
            chk("a2o_d2", pdat_log[2], 16'h02C3);
            for (int i = 0; i < 3; i++) begin
                chk("a2o_vec", push_log[i], 4'b0100);
                chk("a2o_lat", push_cyc[i] - pop_cyc[i], 1);
            end
        end

        // unicast
        clear_logs();
        load(0, 16'h0155);
        drain("uni");
        chk("uni_npush", push_log.size(), 1);
        if (push_log.size() == 1 && pop_log.size() == 1) begin
            chk("uni_pop", pop_log[0], 0);
            chk("uni_vec", push_log[0], 4'b0010);
            chk("uni_data", pdat_log[0], 16'h0155);
            chk("uni_lat", push_cyc[0] - pop_cyc[0], 1);
        end

        // broadcast
        clear_logs();
        load(2, 16'hFF7E);
        drain("bc");
        chk("bc_npush", push_log.size(), 1);
        if (push_log.size() == 1) begin
            chk("bc_vec", push_log[0], 4'b1011);
            chk("bc_data", pdat_log[0], 16'hFF7E);
        end

        // drops: self-addressed then invalid ID
        clear_logs();
        load(1, 16'h0101);
        load(1, 16'h0904);
        drain("drop");
        chk("drop_npop", pop_log.size(), 2);
        chk("drop_npush", push_log.size(), 0);
`ifdef BUS_DROP_CNT_EN
        @(negedge clk); #1;
        chk("drop_cnt_lit", drop_cnt, 2);
`endif

        // round-robin with all agents pending
        do_reset();
        clear_logs();
        @(posedge clk); #2;
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < ND; d++)
                load(d, {8'((d + 1) % ND), 8'(16 * d + k)});
        drain("rr");
        chk("rr_npop", pop_log.size(), 8);
        if (pop_log.size() == 8) begin
            chk("rr_g0", pop_log[0], 0);
            chk("rr_g1", pop_log[1], 1);
            chk("rr_g2", pop_log[2], 2);
            chk("rr_g3", pop_log[3], 3);
            chk("rr_g4", pop_log[4], 0);
            for (int i = 1; i < 5; i++)
                chk("rr_gap", pop_cyc[i] - pop_cyc[i-1], 3);
        end

        // reset during the POP cycle
        load(2, 16'h0311);
        load(3, 16'h0022);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); #1;
                if (pop != '0) begin
                    seen = 1;
                    break;
                end
            end
            chk("rmid_pop_seen", seen, 1);
            chk("rmid_pop_vec", pop, 4'b0100);
        end
        rst = 1'b1;
        @(posedge clk); #2;
        load(0, 16'h0133);
        @(negedge clk); #1;
        chk("rmid_push_off", push, 0);
        chk("rmid_dpush_off", D_push, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        clear_logs();
        drain("rmid");
        chk("rmid_npop", pop_log.size(), 2);
        chk("rmid_npush", push_log.size(), 2);
        if (pop_log.size() == 2 && push_log.size() == 2) begin
            chk("rmid_g0", pop_log[0], 0);
            chk("rmid_g1", pop_log[1], 3);
            chk("rmid_v0", push_log[0], 4'b0010);
            chk("rmid_d0", pdat_log[0], 16'h0133);
            chk("rmid_v1", push_log[1], 4'b0001);
            chk("rmid_d1", pdat_log[1], 16'h0022);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
